// File: rtl/pl_data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : pl_data_mem_responder_if
// Description : Request/response bundle between the memory stage (master)
//               and the data-memory responder (slave).
//   req_valid  m->s  request present
//   req_ready  s->m  responder idle and able to accept
//   req_we     m->s  1 = store, 0 = load
//   req_addr   m->s  byte address
//   req_wdata  m->s  store data, right-aligned
//   req_f3     m->s  RISC-V funct3 (size / sign)
//   resp_valid s->m  one-cycle response pulse
//   resp_rdata s->m  extended load data (0 for stores)
//   resp_err   s->m  access faulted
//   busy       s->m  access in flight, for the hazard unit
// Revision    : 1.0 - initial release
// ============================================================================
interface pl_data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_f3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_f3,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_f3,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/pl_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : pl_data_mem_responder
// Description : Multi-cycle data memory for the pipelined RISC-V core.
//               Accepts one load/store at a time over a valid/ready channel
//               and returns a single response pulse after LATENCY cycles.
//               Stores are byte/half/word masked by funct3; loads are sign-
//               or zero-extended.
// Parameters  : DEPTH   - memory size in 32-bit words (power of two, >= 2)
//               LATENCY - cycles from acceptance to response (>= 1)
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - pl_data_mem_responder_if.slave (request/response)
// Option      : DMEM_MISALIGN_CHECK_EN - when defined, misaligned half/word
//               accesses fault (no write, rdata 0, err 1); otherwise the low
//               address bits are forced to alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module pl_data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  wire logic               clk,
  input  wire logic               rst,
  pl_data_mem_responder_if.slave  bus
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CW-1:0]    r_cnt;
  logic               r_we;
  logic [c_AW+1:0]    r_addr;
  logic [31:0]        r_wdata;
  logic [2:0]         r_f3;
  logic               r_resp_valid;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_err;
  logic [31:0]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_commit;
  logic [c_AW-1:0]    w_idx;
  logic [31:0]        w_rword;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [3:0]         w_be;
  logic [31:0]        w_wword;
  logic [31:0]        w_rdata;
  logic               w_err;
  logic               w_misalign;
  logic               w_unused_addr;

  // Address bits above the memory span are ignored (accesses wrap).
  assign w_unused_addr = ^bus.req_addr[31:c_AW+2];

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  // The access takes effect on the edge that leaves WAIT for RESP.
  assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_idx    = r_addr[c_AW+1:2];
  assign w_rword  = r_mem[w_idx];
  assign w_byte   = w_rword[{r_addr[1:0], 3'b000} +: 8];
  assign w_half   = r_addr[1] ? w_rword[31:16] : w_rword[15:0];

`ifdef DMEM_MISALIGN_CHECK_EN
  // f3[1:0]==01 covers both LH/SH (001) and LHU (101).
  assign w_misalign = ((r_f3[1:0] == 2'b01) && r_addr[0]) ||
                      ((r_f3 == 3'b010) && (r_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Access decode: byte enables and replicated store data for stores,
  // selected and extended data for loads. Alignment is forced implicitly
  // by using only addr[1] for halves and no low bits for words.
  always_comb begin
    w_be    = 4'b0000;
    w_wword = r_wdata;
    w_rdata = 32'd0;
    w_err   = 1'b0;
    if (r_we) begin
      case (r_f3)
        3'b000: begin
          w_be    = 4'b0001 << r_addr[1:0];
          w_wword = {4{r_wdata[7:0]}};
        end
        3'b001: begin
          w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
          w_wword = {2{r_wdata[15:0]}};
        end
        3'b010: w_be = 4'b1111;
        default: w_err = 1'b1;
      endcase
    end else begin
      case (r_f3)
        3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
        3'b010:  w_rdata = w_rword;
        3'b100:  w_rdata = {24'd0, w_byte};
        3'b101:  w_rdata = {16'd0, w_half};
        default: w_err   = 1'b1;
      endcase
    end
    if (w_misalign) begin
      w_be    = 4'b0000;
      w_rdata = 32'd0;
      w_err   = 1'b1;
    end
  end

  // Memory array is never reset; a commit coinciding with reset is dropped
  // so a store interrupted by reset leaves memory untouched.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!rst && w_commit && w_be[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_f3         <= 3'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr[c_AW+1:0];
            r_wdata <= bus.req_wdata;
            r_f3    <= bus.req_f3;
            r_cnt   <= c_CW'(LATENCY - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_rdata;
            r_resp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pl_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pl_data_mem_responder
// Description : Self-checking bench for pl_data_mem_responder. A byte-array
//               reference model predicts each response at acceptance; a
//               monitor pops and compares responses, including latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pl_data_mem_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pl_data_mem_responder_if bus ();

  pl_data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
    string       name;
  } exp_t;
  exp_t q[$];

  logic [7:0] mem_b [DEPTH*4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a flat byte array, access sizes from funct3.
  function automatic void model(input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                output logic [31:0] rd, output logic err);
    int size;
    bit sgn;
    int base;
    logic [31:0] val;
    size = 0;
    sgn  = 0;
    rd   = 32'd0;
    err  = 1'b0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: if (!we) size = 1;
      3'd5: if (!we) size = 2;
      default: size = 0;
    endcase
    if (size == 0) begin
      err = 1'b1;
      return;
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((addr % size) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    base = int'(addr & (DEPTH*4 - 1));
    base = base - (base % size);
    if (we) begin
      for (int i = 0; i < size; i++) mem_b[base+i] = wdata[8*i +: 8];
    end else begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = mem_b[base+i];
      if (sgn && val[8*size-1])
        for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
      rd = val;
    end
  endfunction

  // Monitor: every response must match the oldest prediction, LATENCY
  // cycles after its acceptance edge.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_rdata"}, bus.resp_rdata, e.rd);
        check({e.name, "_err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
        check({e.name, "_latency"}, cyc - e.acc, LATENCY);
      end
    end
  end

  // Present a request, wait (bounded) for acceptance; called at posedge+#1.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input bit hold, input bit track,
                        input string name);
    int   n;
    exp_t e;
    n = 0;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_f3    = f3;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout: got req_ready=0 expected 1 within 20 cycles", name);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (track) begin
      model(we, addr, wdata, f3, e.rd, e.err);
      e.acc  = cyc;
      e.name = name;
      q.push_back(e);
    end
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
    check({name, "_notready"}, {31'd0, bus.req_ready}, 32'd0);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_f3    = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);

    // Give the low 16 words known contents.
    for (int w = 0; w < 16; w++) do_req(1'b1, 32'(w*4), $urandom, 3'd2, 1'b0, 1'b1, "init");

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b0, 1'b1, "sw10");
    do_req(1'b0, 32'h10, 32'd0,        3'd2, 1'b0, 1'b1, "lw10");
    do_req(1'b1, 32'h20, 32'h0,        3'd2, 1'b0, 1'b1, "sw20");
    do_req(1'b1, 32'h23, 32'h80,       3'd0, 1'b0, 1'b1, "sb23");
    do_req(1'b1, 32'h20, 32'h1234,     3'd1, 1'b0, 1'b1, "sh20");
    do_req(1'b0, 32'h20, 32'd0,        3'd2, 1'b0, 1'b1, "lw20");
    do_req(1'b0, 32'h23, 32'd0,        3'd0, 1'b0, 1'b1, "lb23");
    do_req(1'b0, 32'h23, 32'd0,        3'd4, 1'b0, 1'b1, "lbu23");
    do_req(1'b0, 32'h22, 32'd0,        3'd1, 1'b0, 1'b1, "lh22");
    do_req(1'b1, 32'(DEPTH*4 + 4), 32'h55, 3'd2, 1'b0, 1'b1, "sw_wrap");
    do_req(1'b0, 32'h4,  32'd0,        3'd2, 1'b0, 1'b1, "lw_wrap");
    do_req(1'b0, 32'h21, 32'd0,        3'd2, 1'b0, 1'b1, "lw_misalign");
    do_req(1'b1, 32'h10, 32'hAB,       3'd3, 1'b0, 1'b1, "st_badf3");
    do_req(1'b0, 32'h10, 32'd0,        3'd7, 1'b0, 1'b1, "ld_badf3");

    // Second request held valid while the first is in flight.
    do_req(1'b0, 32'h10, 32'd0, 3'd2, 1'b1, 1'b1, "held_a");
    do_req(1'b0, 32'h20, 32'd0, 3'd2, 1'b0, 1'b1, "held_b");

    // Reset during WAIT discards the store and its response.
    do_req(1'b1, 32'h30, 32'h1, 3'd2, 1'b0, 1'b0, "sw_mid");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    do_req(1'b0, 32'h30, 32'd0, 3'd2, 1'b0, 1'b1, "lw_after_mid");

    // Random traffic within the initialised words, with random high bits.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 7)) << 12) | 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
             1'b0, 1'b1, "rand");
    end

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending responses expected 0", q.size());
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
